// File: rtl/watch_pkg.sv
// Shared definitions for the digital-watch controller and datapath.
package watch_pkg;

    localparam int unsigned MS_PER_S      = 1000;
    localparam int unsigned BLINK_HALF_MS = 500;

    typedef enum logic [1:0] {
        RUN,
        SET_HOURS,
        SET_MINUTES,
        SET_SECONDS
    } state_t;

    // One clean command per button, as seen by the watch FSM
    typedef struct packed {
        logic mode;
        logic add;
        logic sub;
    } btn_cmd_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz);
        return clk_hz / MS_PER_S;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button path: 2-FF sync, ms-tick debounce, press pulse and optional auto-repeat.
// Auto-repeat logic exists only when WATCH_CTRL_AUTOREPEAT_EN is defined.
module btn_conditioner
    import watch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS      = 20,
    parameter int unsigned REPEAT_DELAY_MS  = 500,
    parameter int unsigned REPEAT_PERIOD_MS = 100,
    parameter bit          REPEAT_ALLOW     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic held,
    output logic press_c,
    output logic repeat_c
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_MS + 1);

    if (DEBOUNCE_MS == 0 || REPEAT_PERIOD_MS == 0 ||
        (REPEAT_ALLOW && REPEAT_PERIOD_MS > REPEAT_DELAY_MS)) begin : g_bad_cfg
        $error("btn_conditioner: invalid debounce/repeat configuration");
    end

    logic            sync1;
    logic            sync2;
    logic            deb;
    logic            deb_d;
    logic [DB_W-1:0] db_cnt;

    // Synchroniser and debounce: a differing level must survive DEBOUNCE_MS ticks
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (ms_tick) begin
                if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                    deb    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    assign held    = deb;
    assign press_c = deb & ~deb_d;

`ifdef WATCH_CTRL_AUTOREPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY_MS + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              rep_q;

    // After the first repeat the counter is rewound so later repeats land every period
    always_ff @(posedge clock) begin
        if (reset || !deb) begin
            hold_cnt <= '0;
            rep_q    <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (ms_tick) begin
                if (hold_cnt == HOLD_W'(REPEAT_DELAY_MS - 1)) begin
                    hold_cnt <= HOLD_W'(REPEAT_DELAY_MS - REPEAT_PERIOD_MS);
                    rep_q    <= REPEAT_ALLOW;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

    // Gate with the live level so a release cuts off a repeat already in flight
    assign repeat_c = rep_q & deb;
`else
    assign repeat_c = 1'b0;
`endif

endmodule

// File: rtl/watch_ctrl.sv
// Watch timebase (1 Hz strobe, 500 ms blink) and arbitrated button commands.
// Define WATCH_CTRL_AUTOREPEAT_EN to enable add/sub auto-repeat.
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned DEBOUNCE_MS      = 20,
    parameter int unsigned REPEAT_DELAY_MS  = 500,
    parameter int unsigned REPEAT_PERIOD_MS = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_mode_raw,
    input  logic btn_add_raw,
    input  logic btn_sub_raw,
    output logic pulse_1hz,
    output logic pulse_500ms,
    output logic mode_button,
    output logic add_button,
    output logic sub_button
);

    localparam int unsigned CYC_PER_MS = ms_to_cycles(CLK_HZ);
    localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int unsigned MS_W       = $clog2(MS_PER_S);

    if (CLK_HZ < MS_PER_S || (CLK_HZ % MS_PER_S) != 0) begin : g_bad_clk
        $error("watch_ctrl: CLK_HZ must be a non-zero multiple of 1000");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic             ms_tick;

    assign ms_tick = (pre_cnt == PRE_W'(CYC_PER_MS - 1));

    // ms prescaler, ms-of-second counter and the two timebase outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt     <= '0;
            ms_cnt      <= '0;
            pulse_1hz   <= 1'b0;
            pulse_500ms <= 1'b0;
        end else begin
            pre_cnt     <= ms_tick ? '0 : pre_cnt + PRE_W'(1);
            pulse_500ms <= (ms_cnt < MS_W'(BLINK_HALF_MS));
            pulse_1hz   <= 1'b0;
            if (ms_tick) begin
                if (ms_cnt == MS_W'(MS_PER_S - 1)) begin
                    ms_cnt    <= '0;
                    pulse_1hz <= 1'b1;
                end else begin
                    ms_cnt <= ms_cnt + MS_W'(1);
                end
            end
        end
    end

    logic mode_press, mode_rep, mode_held_unused;
    logic add_press, add_rep, add_held;
    logic sub_press, sub_rep, sub_held;

    btn_conditioner #(
        .DEBOUNCE_MS      (DEBOUNCE_MS),
        .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
        .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
        .REPEAT_ALLOW     (1'b0)
    ) u_mode (
        .clock    (clock),
        .reset    (reset),
        .ms_tick  (ms_tick),
        .btn_raw  (btn_mode_raw),
        .held     (mode_held_unused),
        .press_c  (mode_press),
        .repeat_c (mode_rep)
    );

    btn_conditioner #(
        .DEBOUNCE_MS      (DEBOUNCE_MS),
        .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
        .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
        .REPEAT_ALLOW     (1'b1)
    ) u_add (
        .clock    (clock),
        .reset    (reset),
        .ms_tick  (ms_tick),
        .btn_raw  (btn_add_raw),
        .held     (add_held),
        .press_c  (add_press),
        .repeat_c (add_rep)
    );

    btn_conditioner #(
        .DEBOUNCE_MS      (DEBOUNCE_MS),
        .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
        .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
        .REPEAT_ALLOW     (1'b1)
    ) u_sub (
        .clock    (clock),
        .reset    (reset),
        .ms_tick  (ms_tick),
        .btn_raw  (btn_sub_raw),
        .held     (sub_held),
        .press_c  (sub_press),
        .repeat_c (sub_rep)
    );

    btn_cmd_t evt_c;

    // Holding add and sub together freezes repeats; presses still go to arbitration
    always_comb begin
        evt_c      = '0;
        evt_c.mode = mode_press | mode_rep;
        evt_c.add  = add_press | (add_rep & ~(add_held & sub_held));
        evt_c.sub  = sub_press | (sub_rep & ~(add_held & sub_held));
    end

    // mode wins outright; a simultaneous add and sub cancel each other
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_button <= 1'b0;
            add_button  <= 1'b0;
            sub_button  <= 1'b0;
        end else begin
            mode_button <= evt_c.mode;
            add_button  <= evt_c.add & ~evt_c.mode & ~evt_c.sub;
            sub_button  <= evt_c.sub & ~evt_c.mode & ~evt_c.add;
        end
    end

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl at CLK_HZ=1000 (1 ms per cycle); honours WATCH_CTRL_AUTOREPEAT_EN.
`timescale 1ns/1ps
module tb_watch_ctrl;

    localparam int PERIOD_CYC = 1000;

    logic clock = 1'b0;
    logic reset;
    logic btn_mode_raw, btn_add_raw, btn_sub_raw;
    logic pulse_1hz, pulse_500ms, mode_button, add_button, sub_button;

    always #5 clock = ~clock;

    watch_ctrl #(
        .CLK_HZ           (1000),
        .DEBOUNCE_MS      (4),
        .REPEAT_DELAY_MS  (20),
        .REPEAT_PERIOD_MS (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_mode_raw (btn_mode_raw),
        .btn_add_raw  (btn_add_raw),
        .btn_sub_raw  (btn_sub_raw),
        .pulse_1hz    (pulse_1hz),
        .pulse_500ms  (pulse_500ms),
        .mode_button  (mode_button),
        .add_button   (add_button),
        .sub_button   (sub_button)
    );

    int    nvec = 0;
    int    nerr = 0;
    int    cyc  = 0;
    int    hi_cnt = 0;
    string mode_log, add_log, sub_log, hz_log, sub_exp;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        nvec++;
        assert (obs == exp) else begin
            nerr++;
            $error("FAIL %s observed='%s' expected='%s'", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        mode_log = "";
        add_log  = "";
        sub_log  = "";
    endtask

    // One clock; check the timebase against the cycle model and log command pulses
    task automatic step();
        logic e_hz, e_blink;
        @(posedge clock);
        #1;
        cyc++;
        e_hz    = ((cyc % PERIOD_CYC) == 0);
        e_blink = (((cyc - 1) % PERIOD_CYC) < (PERIOD_CYC / 2));
        chk_bit("pulse_1hz", pulse_1hz, e_hz);
        chk_bit("pulse_500ms", pulse_500ms, e_blink);
        chk_bit("onehot_cmd", $onehot0({mode_button, add_button, sub_button}), 1'b1);
        if (mode_button) mode_log = {mode_log, $sformatf("%0d ", cyc)};
        if (add_button)  add_log  = {add_log,  $sformatf("%0d ", cyc)};
        if (sub_button)  sub_log  = {sub_log,  $sformatf("%0d ", cyc)};
        if (pulse_1hz)   hz_log   = {hz_log,   $sformatf("%0d ", cyc)};
        if (pulse_500ms) hi_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bit({tag, "_pulse_1hz"},   pulse_1hz,   1'b0);
        chk_bit({tag, "_pulse_500ms"}, pulse_500ms, 1'b0);
        chk_bit({tag, "_mode"},        mode_button, 1'b0);
        chk_bit({tag, "_add"},         add_button,  1'b0);
        chk_bit({tag, "_sub"},         sub_button,  1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        btn_mode_raw = 1'b0;
        btn_add_raw  = 1'b0;
        btn_sub_raw  = 1'b0;
        hz_log       = "";
        clear_logs();
`ifdef WATCH_CTRL_AUTOREPEAT_EN
        sub_exp = "307 327 332 337 342 ";
`else
        sub_exp = "307 ";
`endif

        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        cyc   = 0;

        // Clean add press: sync 2 + debounce 4 + output 1
        run_to(100);
        clear_logs();
        btn_add_raw = 1'b1;
        run_to(110);
        btn_add_raw = 1'b0;
        run_to(200);
        chk_str("add_press", add_log, "107 ");
        chk_str("add_press_no_mode", mode_log, "");
        chk_str("add_press_no_sub", sub_log, "");

        // Single-cycle glitches never survive debounce
        clear_logs();
        btn_add_raw = 1'b1; step();
        btn_add_raw = 1'b0; step();
        btn_add_raw = 1'b1; step();
        btn_add_raw = 1'b0;
        run_to(300);
        chk_str("glitch_add", add_log, "");

        // Long sub hold: press plus repeats when enabled
        clear_logs();
        btn_sub_raw = 1'b1;
        run_to(340);
        btn_sub_raw = 1'b0;
        run_to(400);
        chk_str("sub_hold", sub_log, sub_exp);
        chk_str("sub_hold_no_add", add_log, "");

        // mode and add together: mode only
        clear_logs();
        btn_mode_raw = 1'b1;
        btn_add_raw  = 1'b1;
        run_to(410);
        btn_mode_raw = 1'b0;
        btn_add_raw  = 1'b0;
        run_to(500);
        chk_str("mode_add_mode", mode_log, "407 ");
        chk_str("mode_add_add", add_log, "");

        // add and sub together, held long: nothing at all
        clear_logs();
        btn_add_raw = 1'b1;
        btn_sub_raw = 1'b1;
        run_to(540);
        btn_add_raw = 1'b0;
        btn_sub_raw = 1'b0;
        run_to(600);
        chk_str("add_sub_add", add_log, "");
        chk_str("add_sub_sub", sub_log, "");
        chk_str("add_sub_mode", mode_log, "");

        // mode held long never repeats
        clear_logs();
        btn_mode_raw = 1'b1;
        run_to(640);
        btn_mode_raw = 1'b0;
        run_to(700);
        chk_str("mode_hold", mode_log, "607 ");

        run_to(1200);
        chk_str("hz_first_period", hz_log, "1000 ");

        // add held across a one-cycle reset at cycle 1500
        run_to(1490);
        clear_logs();
        btn_add_raw = 1'b1;
        run_to(1499);
        chk_str("add_before_reset", add_log, "1497 ");
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_outputs("midreset");
        reset  = 1'b0;
        cyc    = 0;
        hi_cnt = 0;
        hz_log = "";
        clear_logs();
        run_to(15);
        btn_add_raw = 1'b0;
        run_to(100);
        chk_str("add_after_reset", add_log, "7 ");
        chk_str("mode_after_reset", mode_log, "");
        chk_str("sub_after_reset", sub_log, "");

        // Free-run after reset: strobes at 1000/2000/3000, 50% blink
        run_to(1000);
        chk_int("blink_high_count", hi_cnt, 500);
        run_to(3000);
        chk_str("hz_free_run", hz_log, "1000 2000 3000 ");
        chk_int("blink_high_total", hi_cnt, 1500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
